// File: rtl/axi4_lite_pkg.sv
// axi4_lite_pkg: AXI4-Lite response type and codes shared with the write manager
package axi4_lite_pkg;
   typedef logic [1:0] axi4_lite_resp_t;
   localparam axi4_lite_resp_t AXI4_LITE_OKAY   = 2'b00;
   localparam axi4_lite_resp_t AXI4_LITE_SLVERR = 2'b10;
endpackage

// File: rtl/axi4_lite_fifo.sv
// axi4_lite_fifo: registered, non-fall-through FIFO; full FIFO refuses push even on a same-cycle pop
module axi4_lite_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic             clk_i,
   input  logic             rst_clk_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic do_push, do_pop;
   assign full_o  = count == CW'(DEPTH);
   assign empty_o = count == '0;
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign data_o  = mem[rd_ptr];
   always_ff @(posedge clk_i or negedge rst_clk_i)
      if (!rst_clk_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= data_i;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
endmodule

// File: rtl/axi4_lite_write_aligner.sv
// axi4_lite_write_aligner: buffers AW and W independently and re-presents them as pairs
module axi4_lite_write_aligner
   import axi4_lite_pkg::*;
#(
   parameter int ADDRESS_SIZE    = 4,
   parameter int DATA_SIZE       = 32,
   parameter int DEPTH           = 2,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                                 clk_i,
   input  logic                                 rst_clk_i,
   input  logic [ADDRESS_SIZE-1:0]              s_write_address_i,
   input  logic                                 s_write_address_valid_i,
   output logic                                 s_write_address_ready_o,
   input  logic [DATA_SIZE-1:0]                 s_write_data_i,
   input  logic [DATA_SIZE/8-1:0]               s_write_data_strobe_i,
   input  logic                                 s_write_data_valid_i,
   output logic                                 s_write_data_ready_o,
   output axi4_lite_resp_t                      s_write_response_o,
   output logic                                 s_write_response_valid_o,
   input  logic                                 s_write_response_ready_i,
   output logic [ADDRESS_SIZE-1:0]              m_write_address_o,
   output logic                                 m_write_address_valid_o,
   input  logic                                 m_write_address_ready_i,
   output logic [DATA_SIZE-1:0]                 m_write_data_o,
   output logic [DATA_SIZE/8-1:0]               m_write_data_strobe_o,
   output logic                                 m_write_data_valid_o,
   input  logic                                 m_write_data_ready_i,
   input  axi4_lite_resp_t                      m_write_response_i,
   input  logic                                 m_write_response_valid_i,
   output logic                                 m_write_response_ready_o,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
   output logic                                 error_o
);
   localparam int SW = DATA_SIZE / 8;
   localparam int OW = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [OW-1:0] MAX_CNT = OW'(MAX_OUTSTANDING);
   logic aw_full, aw_empty, w_full, w_empty;
   logic aw_sent, w_sent, pair_avail, aw_hs, w_hs, retire, b_hs;
   logic [DATA_SIZE+SW-1:0] w_head;
   axi4_lite_fifo #(.WIDTH(ADDRESS_SIZE), .DEPTH(DEPTH)) u_aw_fifo (
      .clk_i(clk_i), .rst_clk_i(rst_clk_i),
      .push_i(s_write_address_valid_i), .data_i(s_write_address_i),
      .pop_i(retire), .data_o(m_write_address_o),
      .full_o(aw_full), .empty_o(aw_empty)
   );
   axi4_lite_fifo #(.WIDTH(DATA_SIZE + SW), .DEPTH(DEPTH)) u_w_fifo (
      .clk_i(clk_i), .rst_clk_i(rst_clk_i),
      .push_i(s_write_data_valid_i), .data_i({s_write_data_strobe_i, s_write_data_i}),
      .pop_i(retire), .data_o(w_head),
      .full_o(w_full), .empty_o(w_empty)
   );
   assign {m_write_data_strobe_o, m_write_data_o} = w_head;
   assign s_write_address_ready_o = !aw_full;
   assign s_write_data_ready_o    = !w_full;
   assign pair_avail              = !aw_empty && !w_empty && (outstanding_o < MAX_CNT);
   assign m_write_address_valid_o = pair_avail && !aw_sent;
   assign m_write_data_valid_o    = pair_avail && !w_sent;
   assign aw_hs                   = m_write_address_valid_o && m_write_address_ready_i;
   assign w_hs                    = m_write_data_valid_o && m_write_data_ready_i;
   // pair_avail cannot drop while a half is sent: nothing pops and the counter only rises on retire
   assign retire                  = (aw_hs || aw_sent) && (w_hs || w_sent);
   assign s_write_response_o       = m_write_response_i;
   assign s_write_response_valid_o = m_write_response_valid_i;
   assign m_write_response_ready_o = s_write_response_ready_i;
   assign b_hs                     = m_write_response_valid_i && s_write_response_ready_i;
   always_ff @(posedge clk_i or negedge rst_clk_i)
      if (!rst_clk_i) begin
         aw_sent       <= 1'b0;
         w_sent        <= 1'b0;
         outstanding_o <= '0;
         error_o       <= 1'b0;
      end else begin
         aw_sent <= !retire && (aw_sent || aw_hs);
         w_sent  <= !retire && (w_sent || w_hs);
         if (retire && !b_hs) outstanding_o <= outstanding_o + OW'(1);
         else if (b_hs && !retire && outstanding_o != '0) outstanding_o <= outstanding_o - OW'(1);
         if (b_hs && !retire && outstanding_o == '0) error_o <= 1'b1;
      end
endmodule
